// File: rtl/multicycle_main_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control FSM.
// Holds the widths, opcode constants, state encodings and mux select encodings.
// Imported by multicycle_main_ctrl and mc_ctrl_out_dec.
package multicycle_main_ctrl_pkg;

    localparam int OPW  = 6;   // opcode width (Instr[31:26])
    localparam int SELW = 2;   // width of every mux select
    localparam int STW  = 4;   // state register width

    // Supported opcodes
    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_J     = 6'b000010;
    localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [OPW-1:0] OP_SW    = 6'b101011;

    // 12 encoded states; codes 12..15 are unused and recover to FETCH
    typedef enum logic [STW-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // ALU B-operand select
    localparam logic [SELW-1:0] ALUB_RT     = 2'b00;
    localparam logic [SELW-1:0] ALUB_FOUR   = 2'b01;
    localparam logic [SELW-1:0] ALUB_IMM    = 2'b10;
    localparam logic [SELW-1:0] ALUB_IMMSH2 = 2'b11;

    // ALU operation select
    localparam logic [SELW-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SELW-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SELW-1:0] ALUOP_FUNCT = 2'b10;

    // PC-source mux select (2'b11 is never produced)
    localparam logic [SELW-1:0] PCSRC_PC4    = 2'b00;
    localparam logic [SELW-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SELW-1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic op_is_legal(input logic [OPW-1:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: op_is_legal = 1'b1;
            default:                                        op_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_main_ctrl_out_dec.sv
// mc_ctrl_out_dec: combinational state -> control-word decoder with PCEn/MemReady gating.
// Ports: i_state/i_opcode/i_zero/i_mem_ready/i_rst_n in; every datapath select and enable out.
// Zero latency; strobes are forced low while i_rst_n is low.
module mc_ctrl_out_dec
    import multicycle_main_ctrl_pkg::*;
(
    input  logic [STW-1:0]  i_state,
    input  logic [OPW-1:0]  i_opcode,
    input  logic            i_zero,
    input  logic            i_mem_ready,
    input  logic            i_rst_n,
    output logic            o_iord,
    output logic            o_mem_write,
    output logic            o_ir_write,
    output logic            o_reg_dst,
    output logic            o_mem_to_reg,
    output logic            o_reg_write,
    output logic            o_alu_src_a,
    output logic [SELW-1:0] o_alu_src_b,
    output logic [SELW-1:0] o_alu_op,
    output logic [SELW-1:0] o_pc_src,
    output logic            o_pc_en,
    output logic            o_illegal
);

    logic w_mem_write;
    logic w_ir_write;
    logic w_reg_write;
    logic w_pc_en;
    logic w_illegal;

    always_comb begin
        // Idle control word: everything off, ALU B parked on constant 4
        o_iord       = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        o_reg_dst    = 1'b0;
        o_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        o_alu_src_a  = 1'b0;
        o_alu_src_b  = ALUB_FOUR;
        o_alu_op     = ALUOP_ADD;
        o_pc_src     = PCSRC_PC4;
        w_pc_en      = 1'b0;
        w_illegal    = 1'b0;
        case (state_t'(i_state))
            S_FETCH: begin
                // PC+4 and the IR load both complete only when memory returns the word
                w_ir_write = i_mem_ready;
                w_pc_en    = i_mem_ready;
            end
            S_DECODE: begin
                o_alu_src_b = ALUB_IMMSH2;    // branch target into ALUOut
                w_illegal   = !op_is_legal(i_opcode);
            end
            S_MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = ALUB_IMM;
            end
            S_MEMRD: begin
                o_iord = 1'b1;
            end
            S_MEMWB: begin
                o_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
            end
            S_MEMWR: begin
                o_iord      = 1'b1;
                w_mem_write = i_mem_ready;
            end
            S_EXEC: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = ALUB_RT;
                o_alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = ALUB_RT;
                o_alu_op    = ALUOP_SUB;
                o_pc_src    = PCSRC_ALUOUT;
                w_pc_en     = i_zero;         // PCWrite=0, Branch=1
            end
            S_ADDIEX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = ALUB_IMM;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
            end
            S_JUMP: begin
                o_pc_src = PCSRC_JUMP;
                w_pc_en  = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset holds the state at FETCH, but FETCH alone would still pass MemReady through
    assign o_mem_write = w_mem_write & i_rst_n;
    assign o_ir_write  = w_ir_write  & i_rst_n;
    assign o_reg_write = w_reg_write & i_rst_n;
    assign o_pc_en     = w_pc_en     & i_rst_n;
    assign o_illegal   = w_illegal   & i_rst_n;

endmodule

// File: rtl/multicycle_main_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: state register and next-state logic.
// Ports: CLK/RST_N, Opcode/Zero/MemReady in; datapath selects, enables, Illegal, State out.
// FETCH/MEMRD/MEMWR stall on MemReady; other states advance every cycle.
module multicycle_main_ctrl
    import multicycle_main_ctrl_pkg::*;
(
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [OPW-1:0]  Opcode,
    input  logic            Zero,
    input  logic            MemReady,
    output logic            IorD,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            RegDst,
    output logic            MemtoReg,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [SELW-1:0] ALUSrcB,
    output logic [SELW-1:0] ALUOp,
    output logic [SELW-1:0] PCSrc,
    output logic            PCEn,
    output logic            Illegal,
    output logic [STW-1:0]  State
);

    state_t r_state;
    state_t w_state_nxt;

    always_comb begin
        w_state_nxt = S_FETCH;
        case (r_state)
            S_FETCH:  w_state_nxt = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: w_state_nxt = S_MEMADR;
                    OP_RTYPE:     w_state_nxt = S_EXEC;
                    OP_BEQ:       w_state_nxt = S_BRANCH;
                    OP_ADDI:      w_state_nxt = S_ADDIEX;
                    OP_J:         w_state_nxt = S_JUMP;
                    default:      w_state_nxt = S_FETCH;   // illegal: run as NOP
                endcase
            end
            S_MEMADR: w_state_nxt = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_state_nxt = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_state_nxt = MemReady ? S_FETCH : S_MEMWR;
            S_EXEC:   w_state_nxt = S_ALUWB;
            S_ADDIEX: w_state_nxt = S_ADDIWB;
            default:  w_state_nxt = S_FETCH;   // writebacks, BRANCH, JUMP, unused codes
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_FETCH;
        else        r_state <= w_state_nxt;
    end

    assign State = r_state;

    mc_ctrl_out_dec u_out_dec (
        .i_state      (r_state),
        .i_opcode     (Opcode),
        .i_zero       (Zero),
        .i_mem_ready  (MemReady),
        .i_rst_n      (RST_N),
        .o_iord       (IorD),
        .o_mem_write  (MemWrite),
        .o_ir_write   (IRWrite),
        .o_reg_dst    (RegDst),
        .o_mem_to_reg (MemtoReg),
        .o_reg_write  (RegWrite),
        .o_alu_src_a  (ALUSrcA),
        .o_alu_src_b  (ALUSrcB),
        .o_alu_op     (ALUOp),
        .o_pc_src     (PCSrc),
        .o_pc_en      (PCEn),
        .o_illegal    (Illegal)
    );

endmodule

// File: tb/tb_multicycle_main_ctrl.sv
// Directed bench for multicycle_main_ctrl.
// Control outputs are packed into one word:
// {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc,PCEn,Illegal}
module tb_multicycle_main_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       PCEn, Illegal;
    logic [3:0] State;

    int n_cmp = 0;
    int n_err = 0;
    logic seen_pcsrc11 = 1'b0;

    // Hand-computed control words, fields as in the header
    localparam logic [15:0] W_RESET   = 16'b0_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [15:0] W_FETCH   = 16'b0_0_1_0_0_0_0_01_00_00_1_0;
    localparam logic [15:0] W_FSTALL  = 16'b0_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [15:0] W_DECODE  = 16'b0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [15:0] W_DEC_ILL = 16'b0_0_0_0_0_0_0_11_00_00_0_1;
    localparam logic [15:0] W_MEMADR  = 16'b0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [15:0] W_MEMRD   = 16'b1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [15:0] W_MEMWB   = 16'b0_0_0_0_1_1_0_01_00_00_0_0;
    localparam logic [15:0] W_MEMWR   = 16'b1_1_0_0_0_0_0_01_00_00_0_0;
    localparam logic [15:0] W_WRSTALL = 16'b1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [15:0] W_EXEC    = 16'b0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [15:0] W_ALUWB   = 16'b0_0_0_1_0_1_0_01_00_00_0_0;
    localparam logic [15:0] W_BR_T    = 16'b0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [15:0] W_BR_N    = 16'b0_0_0_0_0_0_1_00_01_01_0_0;
    localparam logic [15:0] W_ADDIEX  = 16'b0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [15:0] W_ADDIWB  = 16'b0_0_0_0_0_1_0_01_00_00_0_0;
    localparam logic [15:0] W_JUMP    = 16'b0_0_0_0_0_0_0_01_00_10_1_0;

    logic [15:0] ctl_word;
    assign ctl_word = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                       ALUSrcB, ALUOp, PCSrc, PCEn, Illegal};

    multicycle_main_ctrl dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .Opcode   (Opcode),
        .Zero     (Zero),
        .MemReady (MemReady),
        .IorD     (IorD),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUOp    (ALUOp),
        .PCSrc    (PCSrc),
        .PCEn     (PCEn),
        .Illegal  (Illegal),
        .State    (State)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) if (PCSrc == 2'b11) seen_pcsrc11 <= 1'b1;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with inputs already set: settle, check, advance one cycle
    task automatic cyc_chk(input string tag, input logic [3:0] st, input logic [15:0] w);
        #1;
        chk_eq({tag, ".state"}, {28'd0, State}, {28'd0, st});
        chk_eq({tag, ".ctl"},   {16'd0, ctl_word}, {16'd0, w});
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N    = 1'b0;
        Opcode   = 6'b000000;
        Zero     = 1'b0;
        MemReady = 1'b1;   // high during reset so the strobe gating is exercised
        repeat (3) @(posedge CLK);
        #1;
        chk_eq("reset.state", {28'd0, State}, 32'd0);
        chk_eq("reset.ctl", {16'd0, ctl_word}, {16'd0, W_RESET});
        RST_N = 1'b1;

        // LW: 5 cycles
        Opcode = 6'b100011;
        cyc_chk("lw.c1", 4'd0, W_FETCH);
        cyc_chk("lw.c2", 4'd1, W_DECODE);
        cyc_chk("lw.c3", 4'd2, W_MEMADR);
        cyc_chk("lw.c4", 4'd3, W_MEMRD);
        cyc_chk("lw.c5", 4'd4, W_MEMWB);

        // SW with 4 stalled cycles in MEMWR
        Opcode = 6'b101011;
        cyc_chk("sw.c1", 4'd0, W_FETCH);
        cyc_chk("sw.c2", 4'd1, W_DECODE);
        cyc_chk("sw.c3", 4'd2, W_MEMADR);
        MemReady = 1'b0;
        for (int i = 0; i < 4; i++) cyc_chk("sw.stall", 4'd5, W_WRSTALL);
        MemReady = 1'b1;
        cyc_chk("sw.wr", 4'd5, W_MEMWR);

        // FETCH stall, then RTYPE
        Opcode   = 6'b000000;
        MemReady = 1'b0;
        cyc_chk("rt.fstall", 4'd0, W_FSTALL);
        MemReady = 1'b1;
        cyc_chk("rt.c1", 4'd0, W_FETCH);
        cyc_chk("rt.c2", 4'd1, W_DECODE);
        cyc_chk("rt.c3", 4'd6, W_EXEC);
        cyc_chk("rt.c4", 4'd7, W_ALUWB);

        // ADDI
        Opcode = 6'b001000;
        cyc_chk("addi.c1", 4'd0, W_FETCH);
        cyc_chk("addi.c2", 4'd1, W_DECODE);
        cyc_chk("addi.c3", 4'd9, W_ADDIEX);
        cyc_chk("addi.c4", 4'd10, W_ADDIWB);

        // BEQ taken, then not taken; MemReady low in BRANCH must not matter
        Opcode = 6'b000100;
        Zero   = 1'b1;
        cyc_chk("beqt.c1", 4'd0, W_FETCH);
        cyc_chk("beqt.c2", 4'd1, W_DECODE);
        MemReady = 1'b0;
        cyc_chk("beqt.c3", 4'd8, W_BR_T);
        MemReady = 1'b1;
        Zero     = 1'b0;
        cyc_chk("beqn.c1", 4'd0, W_FETCH);
        cyc_chk("beqn.c2", 4'd1, W_DECODE);
        cyc_chk("beqn.c3", 4'd8, W_BR_N);

        // J
        Opcode = 6'b000010;
        cyc_chk("j.c1", 4'd0, W_FETCH);
        cyc_chk("j.c2", 4'd1, W_DECODE);
        cyc_chk("j.c3", 4'd11, W_JUMP);

        // Illegal opcode: one-cycle pulse in DECODE, back to FETCH
        Opcode = 6'b111111;
        cyc_chk("ill.c1", 4'd0, W_FETCH);
        cyc_chk("ill.c2", 4'd1, W_DEC_ILL);
        cyc_chk("ill.c3", 4'd0, W_FETCH);

        // Reset pulsed during MEMRD
        Opcode = 6'b100011;
        cyc_chk("rst.c2", 4'd1, W_DECODE);
        cyc_chk("rst.c3", 4'd2, W_MEMADR);
        #1;
        chk_eq("rst.inmemrd", {28'd0, State}, 32'd3);
        #2;
        RST_N = 1'b0;
        #1;
        chk_eq("rst.async.state", {28'd0, State}, 32'd0);
        chk_eq("rst.async.ctl", {16'd0, ctl_word}, {16'd0, W_RESET});
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        cyc_chk("rst.after", 4'd0, W_FETCH);

        chk_eq("pcsrc.never11", {31'd0, seen_pcsrc11}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
